shift_lane_sched: RTL and testbench

Two-requester scheduler for a single serial shift-register lane (enable-gated D register chain driven by a `Din`/`En` pair). It accepts parallel words from two requesters, arbitrates round-robin, and serializes the winning word LSB-first onto the lane's `Din`/`En` inputs. A `STALL` input freezes the lane mid-word. The block sits in front of the enable register chain and is the only driver of its `Din` and `En`.

---
 rtl/shift_lane_pkg.sv | 17 +
 rtl/rr_arb2.sv | 24 ++
 rtl/shift_lane_sched.sv | 123 ++++++++++++
 tb/tb_shift_lane_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_lane_pkg.sv
// Shared definitions for the shift-lane scheduler.
//   state_e        : scheduler FSM state encoding (idle / shifting / done pulse)
//   Owner0, Owner1 : OWNER encoding, equal to the requester index
//   LastOwnerRst   : reset value of the round-robin pointer, so requester 0 wins the first tie
package shift_lane_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic Owner0       = 1'b0;
    localparam logic Owner1       = 1'b1;
    localparam logic LastOwnerRst = Owner1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req  : request vector, bit i from requester i
//   last : index of the requester granted most recently
//   gnt  : one-hot grant (all zero when nobody requests)
//   idx  : index of the granted requester (0 when nobody requests)
module rr_arb2
    import shift_lane_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx
);

    always_comb begin
        gnt = req;
        // On a tie the requester that did not win last time gets the lane.
        if (req == 2'b11) begin
            gnt = (last == Owner1) ? 2'b01 : 2'b10;
        end
        idx = gnt[1];
    end

endmodule

// File: rtl/shift_lane_sched.sv
// Round-robin scheduler serializing parallel words LSB-first onto a serial shift lane.
//   CLK, RST      : clock and synchronous active-high reset
//   REQ0/1        : level requests, held until granted
//   DATA0/1       : words to send, stable while the matching request is high
//   STALL         : freezes the lane while shifting
//   GNT0/1        : one-cycle grant; the word is captured in that cycle
//   SR_DIN, SR_EN : serial data and shift enable for the lane
//   BUSY          : not idle
//   OWNER         : current or last granted requester
//   DONE          : one-cycle pulse after the last bit has been shifted
module shift_lane_sched
    import shift_lane_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    input  logic             STALL,
    output logic             GNT0,
    output logic             GNT1,
    output logic             SR_DIN,
    output logic             SR_EN,
    output logic             BUSY,
    output logic             OWNER,
    output logic             DONE
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             owner_q;
    logic             last_owner_q;

    logic [1:0] arb_gnt;
    logic       arb_idx;
    logic       idle;

    rr_arb2 u_arb (
        .req  ({REQ1, REQ0}),
        .last (last_owner_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign idle = (state_q == StIdle);

    // Grants only exist in IDLE and never while reset is being applied.
    assign GNT0   = idle && !RST && arb_gnt[0];
    assign GNT1   = idle && !RST && arb_gnt[1];
    assign SR_EN  = (state_q == StShift) && !STALL;
    assign SR_DIN = (state_q == StShift) ? word_q[cnt_q] : 1'b0;
    assign BUSY   = !idle;
    assign DONE   = (state_q == StDone);
    assign OWNER  = owner_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            word_q       <= '0;
            owner_q      <= Owner0;
            last_owner_q <= LastOwnerRst;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arb_gnt != 2'b00) begin
                        word_q  <= arb_idx ? DATA1 : DATA0;
                        owner_q <= arb_idx;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (!STALL) begin
                        // Stop counting at the last bit so cnt never reaches WIDTH.
                        if (cnt_q == CntLast) begin
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    last_owner_q <= owner_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Tracks a grant that has not yet been closed by its DONE pulse.
    logic gnt_open_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_open_q <= 1'b0;
        end else if (GNT0 || GNT1) begin
            gnt_open_q <= 1'b1;
        end else if (DONE) begin
            gnt_open_q <= 1'b0;
        end
    end

    a_gnt_onehot : assert property (@(posedge CLK) !(GNT0 && GNT1));
    a_en_in_shift : assert property (@(posedge CLK) SR_EN |-> (state_q == StShift));
    a_done_no_en : assert property (@(posedge CLK) DONE |-> !SR_EN);
    a_cnt_range : assert property (@(posedge CLK) 32'(cnt_q) < WIDTH);
    a_gnt_after_done : assert property (@(posedge CLK) disable iff (RST)
        (GNT0 || GNT1) |-> !gnt_open_q);
    a_done_after_gnt : assert property (@(posedge CLK) disable iff (RST)
        DONE |-> gnt_open_q);
`endif

endmodule

// File: tb/tb_shift_lane_sched.sv
module tb_shift_lane_sched;

    logic       clk;
    logic       rst, req0, req1, stall;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, sr_din, sr_en, busy, owner, done;

    logic       rst_b, req0_b, req1_b, stall_b;
    logic [1:0] data0_b, data1_b;
    logic       gnt0_b, gnt1_b, sr_din_b, sr_en_b, busy_b, owner_b, done_b;

    int checks   = 0;
    int failures = 0;

    shift_lane_sched #(.WIDTH(8)) dut (
        .CLK    (clk),
        .RST    (rst),
        .REQ0   (req0),
        .REQ1   (req1),
        .DATA0  (data0),
        .DATA1  (data1),
        .STALL  (stall),
        .GNT0   (gnt0),
        .GNT1   (gnt1),
        .SR_DIN (sr_din),
        .SR_EN  (sr_en),
        .BUSY   (busy),
        .OWNER  (owner),
        .DONE   (done)
    );

    shift_lane_sched #(.WIDTH(2)) dut_w2 (
        .CLK    (clk),
        .RST    (rst_b),
        .REQ0   (req0_b),
        .REQ1   (req1_b),
        .DATA0  (data0_b),
        .DATA1  (data1_b),
        .STALL  (stall_b),
        .GNT0   (gnt0_b),
        .GNT1   (gnt1_b),
        .SR_DIN (sr_din_b),
        .SR_EN  (sr_en_b),
        .BUSY   (busy_b),
        .OWNER  (owner_b),
        .DONE   (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, r0, r1;
        logic [7:0] d0, d1;
        logic       stall;
        logic       g0, g1, din, en, busy, own, done;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(logic rst_v, logic r0, logic r1, logic [7:0] d0, logic [7:0] d1,
                                logic st, logic g0, logic g1, logic din, logic en,
                                logic bsy, logic own, logic dn);
        vec_t v;
        v.rst = rst_v; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.stall = st;
        v.g0 = g0; v.g1 = g1; v.din = din; v.en = en; v.busy = bsy; v.own = own; v.done = dn;
        return v;
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grant_cyc[$];
        int grant_idx[$];
        int both_cnt, g1_cnt, done_cnt, busy_late, pend, pend_idx;
        logic [7:0] a5_bits;

        // 0xA5 LSB-first: 1,0,1,0,0,1,0,1 ; 0x0F LSB-first: 1,1,1,1,0,0,0,0
        a5_bits = 8'hA5;
        vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 8'hA5, 8'h00, 0,  1, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 8; b++) begin
            vecs[2 + b] = mk(0, 0, 0, 8'h00, 8'h00, 0,  0, 0, a5_bits[b], 1, 1, 0, 0);
        end
        vecs[10] = mk(0, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 0, 1, 0, 1);
        vecs[11] = mk(0, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 8'h00, 8'h0F, 0,  0, 1, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 1, 1, 1, 1, 0);
        vecs[14] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 1, 1, 1, 1, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 8'h0F, 1,  0, 0, 1, 0, 1, 1, 0);
        vecs[16] = mk(0, 0, 0, 8'h00, 8'h0F, 1,  0, 0, 1, 0, 1, 1, 0);
        vecs[17] = mk(0, 0, 0, 8'h00, 8'h0F, 1,  0, 0, 1, 0, 1, 1, 0);
        vecs[18] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 1, 1, 1, 1, 0);
        vecs[19] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 1, 1, 1, 1, 0);
        vecs[20] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 0, 1, 1, 1, 0);
        vecs[21] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 0, 1, 1, 1, 0);
        vecs[22] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 0, 1, 1, 1, 0);
        vecs[23] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 0, 1, 1, 1, 0);
        vecs[24] = mk(0, 0, 0, 8'h00, 8'h0F, 0,  0, 0, 0, 0, 1, 1, 1);
        vecs[25] = mk(0, 0, 0, 8'h00, 8'h00, 1,  0, 0, 0, 0, 0, 1, 0);
        vecs[26] = mk(0, 1, 0, 8'hA5, 8'h00, 0,  1, 0, 0, 0, 0, 1, 0);
        for (int b = 0; b < 4; b++) begin
            vecs[27 + b] = mk(0, 0, 0, 8'h00, 8'h00, 0,  0, 0, a5_bits[b], 1, 1, 0, 0);
        end
        // Reset lands while bit 4 is on the lane.
        vecs[31] = mk(1, 0, 0, 8'h00, 8'h00, 0,  0, 0, a5_bits[4], 1, 1, 0, 0);
        vecs[32] = mk(0, 0, 0, 8'h00, 8'h00, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[33] = mk(0, 1, 1, 8'hA5, 8'h0F, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[34] = mk(0, 0, 1, 8'h00, 8'h0F, 0,  0, 0, 1, 1, 1, 0, 0);

        rst = 1; req0 = 0; req1 = 0; data0 = '0; data1 = '0; stall = 0;
        rst_b = 1; req0_b = 0; req1_b = 0; data0_b = '0; data1_b = '0; stall_b = 0;
        repeat (2) next_cycle();
        rst_b = 0;

        // Tests 1, 3, 4: per-cycle vectors.
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
            data0 = vecs[i].d0; data1 = vecs[i].d1; stall = vecs[i].stall;
            @(negedge clk);
            check($sformatf("v%0d_gnt0", i), gnt0, vecs[i].g0);
            check($sformatf("v%0d_gnt1", i), gnt1, vecs[i].g1);
            check($sformatf("v%0d_sr_din", i), sr_din, vecs[i].din);
            check($sformatf("v%0d_sr_en", i), sr_en, vecs[i].en);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_owner", i), owner, vecs[i].own);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            next_cycle();
        end

        // Test 2: both requests held, grants alternate every WIDTH+2 cycles.
        rst = 1; req0 = 0; req1 = 0; stall = 0;
        next_cycle();
        rst = 0; req0 = 1; req1 = 1; data0 = 8'h3C; data1 = 8'hC3;
        both_cnt = 0; pend = 0; pend_idx = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pend != 0) check($sformatf("alt_owner_c%0d", c), owner, pend_idx[0]);
            pend = 0;
            if (gnt0 && gnt1) both_cnt++;
            if (gnt0 || gnt1) begin
                grant_cyc.push_back(c);
                grant_idx.push_back(gnt1 ? 1 : 0);
                pend = 1;
                pend_idx = gnt1 ? 1 : 0;
            end
            next_cycle();
        end
        check_int("alt_both_gnt", both_cnt, 0);
        check_int("alt_grant_count", grant_cyc.size(), 4);
        for (int k = 0; k < grant_cyc.size() && k < 4; k++) begin
            check_int($sformatf("alt_idx_%0d", k), grant_idx[k], k % 2);
            check_int($sformatf("alt_cycle_%0d", k), grant_cyc[k], 10 * k);
        end

        // Test 5: REQ1 pulsed during SHIFT is never granted.
        rst = 1; req0 = 0; req1 = 0;
        next_cycle();
        rst = 0; req0 = 1; data0 = 8'h5A;
        g1_cnt = 0; done_cnt = 0; busy_late = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c == 0) check("pulse_gnt0", gnt0, 1'b1);
            if (gnt1) g1_cnt++;
            if (done) done_cnt++;
            if (c == 9) check("pulse_done_cycle", done, 1'b1);
            if (c >= 10 && busy) busy_late++;
            next_cycle();
            req0 = 0;
            req1 = (c == 2);
        end
        check_int("pulse_no_gnt1", g1_cnt, 0);
        check_int("pulse_one_done", done_cnt, 1);
        check_int("pulse_idle_after", busy_late, 0);

        // Test 6: WIDTH=2, word 2'b10 goes out as 0 then 1, DONE at t+3.
        req0_b = 1; data0_b = 2'b10;
        @(negedge clk);
        check("w2_gnt0", gnt0_b, 1'b1);
        next_cycle();
        req0_b = 0;
        @(negedge clk);
        check("w2_bit0_din", sr_din_b, 1'b0);
        check("w2_bit0_en", sr_en_b, 1'b1);
        next_cycle();
        @(negedge clk);
        check("w2_bit1_din", sr_din_b, 1'b1);
        check("w2_bit1_en", sr_en_b, 1'b1);
        next_cycle();
        @(negedge clk);
        check("w2_done", done_b, 1'b1);
        check("w2_done_en", sr_en_b, 1'b0);
        next_cycle();
        @(negedge clk);
        check("w2_idle_busy", busy_b, 1'b0);
        check("w2_idle_done", done_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
